piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly upstream of the serial sequence detector and drives its `din` bitstream. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB-first or LSB-first. A one-entry holding register allows consecutive words to be streamed with no idle gap. Framing, bit-index and word-count sideband outputs are provided for downstream monitoring.

---
 rtl/piso_serializer.sv | 138 +++++++++++++
 tb/tb_piso_serializer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out stage. Accepts WIDTH-bit words over a valid/ready
// handshake and shifts them out one bit per clock, MSB-first or LSB-first.
// A one-entry holding register lets consecutive words stream with no gap.
//
// Ports
//   clk          in   clock, rising edge
//   clear_n      in   asynchronous active-low reset
//   load_data    in   parallel word to serialize
//   load_valid   in   load_data valid this cycle
//   load_ready   out  word can be accepted this cycle (registers only)
//   sout         out  serial bit (0 when idle)
//   sout_valid   out  sout carries a payload bit
//   frame_last   out  sout is the final bit of the current word
//   bit_count    out  shift-order index of the bit on sout
//   word_count   out  completed words, wrapping at 8 bits
//
// state | meaning
// IDLE  | nothing to shift, waiting for a word
// SHIFT | presenting bit r_bit_cnt of the word in r_shreg
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     frame_last,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic [7:0]               word_count
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [WIDTH-1:0]   r_shreg,     w_shreg_nxt;
    logic [CNT_W-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
    logic [WIDTH-1:0]   r_hold_reg,  w_hold_reg_nxt;
    logic               r_hold_full, w_hold_full_nxt;
    logic [7:0]         r_word_cnt,  w_word_cnt_nxt;

    logic               w_xfer;
    logic               w_last_bit;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_shifted;

    assign load_ready = clear_n & ~r_hold_full;
    assign w_xfer     = load_valid & load_ready;
    assign w_last_bit = (r_bit_cnt == LAST_IDX);

    // The output end of the shift register is fixed by MSB_FIRST; shifting
    // always moves the next bit toward that end and zero-fills behind it.
    assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_hold_reg  <= '0;
            r_hold_full <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_hold_reg  <= w_hold_reg_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_hold_reg_nxt  = r_hold_reg;
        w_hold_full_nxt = r_hold_full;
        w_word_cnt_nxt  = r_word_cnt;

        case (r_state)
            IDLE: begin
                // Words accepted while idle go straight into the shifter.
                if (w_xfer) begin
                    w_shreg_nxt   = load_data;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_last_bit) begin
                    w_shreg_nxt   = w_shifted;
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (w_xfer) begin
                        w_hold_reg_nxt  = load_data;
                        w_hold_full_nxt = 1'b1;
                    end
                end else begin
                    w_word_cnt_nxt = r_word_cnt + 8'd1;
                    // A held word has priority; load_ready is low while it is
                    // held, so no new transfer can collide with it here.
                    if (r_hold_full) begin
                        w_shreg_nxt     = r_hold_reg;
                        w_hold_full_nxt = 1'b0;
                        w_bit_cnt_nxt   = '0;
                    end else if (w_xfer) begin
                        w_shreg_nxt   = load_data;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sout       = (r_state == SHIFT) & w_out_bit;
    assign sout_valid = (r_state == SHIFT);
    assign frame_last = (r_state == SHIFT) & w_last_bit;
    assign bit_count  = r_bit_cnt;
    assign word_count = r_word_cnt;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk;
    logic         clear_n;
    logic         load_valid;
    logic [W-1:0] load_data;

    // index 0: MSB-first instance, index 1: LSB-first instance
    logic         ready_w [2];
    logic         sout_w  [2];
    logic         sv_w    [2];
    logic         fl_w    [2];
    logic [2:0]   bc_w    [2];
    logic [7:0]   wc_w    [2];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .clear_n(clear_n), .load_data(load_data),
        .load_valid(load_valid), .load_ready(ready_w[0]), .sout(sout_w[0]),
        .sout_valid(sv_w[0]), .frame_last(fl_w[0]), .bit_count(bc_w[0]),
        .word_count(wc_w[0])
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .clear_n(clear_n), .load_data(load_data),
        .load_valid(load_valid), .load_ready(ready_w[1]), .sout(sout_w[1]),
        .sout_valid(sv_w[1]), .frame_last(fl_w[1]), .bit_count(bc_w[1]),
        .word_count(wc_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is modelled as a queue of bits still to be emitted (the
    // front is what is on sout) plus an optional waiting word.
    logic       q0 [$];
    logic       q1 [$];
    logic [7:0] hw [2];
    logic       hv [2];
    logic [7:0] wc [2];
    int         done;
    logic       last_xfer;

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic qfront(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int m);
        if (m == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qload(input int m, input logic [7:0] d);
        for (int i = 0; i < W; i++) begin
            if (m == 0) q0.push_back(d[W-1-i]);
            else        q1.push_back(d[i]);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int m = 0; m < 2; m++) begin
            hv[m] = 1'b0;
            hw[m] = '0;
            wc[m] = '0;
        end
        done = 0;
    endtask

    task automatic model_edge();
        logic x;
        logic last;
        x = clear_n && load_valid && !hv[0];
        last_xfer = x;
        if (!clear_n) return;
        for (int m = 0; m < 2; m++) begin
            if (qsize(m) == 0) begin
                if (x) qload(m, load_data);
            end else begin
                last = (qsize(m) == 1);
                qpop(m);
                if (last) begin
                    wc[m] = wc[m] + 8'd1;
                    if (m == 0) done++;
                    if (hv[m]) begin
                        qload(m, hw[m]);
                        hv[m] = 1'b0;
                    end else if (x) begin
                        qload(m, load_data);
                    end
                end else if (x) begin
                    hw[m] = load_data;
                    hv[m] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int n;
        for (int m = 0; m < 2; m++) begin
            n = qsize(m);
            chk($sformatf("sout_valid[%0d]", m), int'(sv_w[m]), int'(n > 0));
            chk($sformatf("sout[%0d]", m), int'(sout_w[m]),
                (n > 0) ? int'(qfront(m)) : 0);
            chk($sformatf("frame_last[%0d]", m), int'(fl_w[m]), int'(n == 1));
            if (n > 0)
                chk($sformatf("bit_count[%0d]", m), int'(bc_w[m]), W - n);
            chk($sformatf("word_count[%0d]", m), int'(wc_w[m]), int'(wc[m]));
            chk($sformatf("load_ready[%0d]", m), int'(ready_w[m]),
                int'(clear_n && !hv[m]));
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        clear_n = 1'b0;
        model_reset();
        #1;
        // No clock edge has happened since clear_n fell.
        chk("rst_async_sout",       int'(sout_w[0]),  0);
        chk("rst_async_sout_valid", int'(sv_w[0]),    0);
        chk("rst_async_bit_count",  int'(bc_w[0]),    0);
        chk("rst_async_word_count", int'(wc_w[0]),    0);
        chk("rst_async_load_ready", int'(ready_w[0]), 0);
        compare_all();
        step();
        step();
        #2;
        clear_n = 1'b1;
        #1;
        chk("rst_release_ready", int'(ready_w[0]), 1);
        compare_all();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] msb_seq;   // expected bits in output order, first at [7]
        logic [7:0] lsb_seq;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0]  s0, s1;
        logic [15:0] s16;
        logic [23:0] s24;
        int          nv;
        int          xe [$];
        int          idx;
        logic [7:0]  words [3];
        int          sent;
        int          prev;
        bit          fin, hit255;

        vecs[0] = '{8'hDB, 8'hDB, 8'hDB};
        vecs[1] = '{8'h1B, 8'h1B, 8'hD8};
        vecs[2] = '{8'hD8, 8'hD8, 8'h1B};
        vecs[3] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[4] = '{8'h0F, 8'h0F, 8'hF0};
        vecs[5] = '{8'h80, 8'h80, 8'h01};

        clear_n    = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        model_reset();
        #1;
        do_reset();

        // ---- table-driven single words ----
        foreach (vecs[v]) begin
            load_valid = 1'b1;
            load_data  = vecs[v].data;
            step();
            load_valid = 1'b0;
            s0 = '0;
            s1 = '0;
            for (int k = 0; k < W; k++) begin
                s0 = {s0[6:0], sout_w[0]};
                s1 = {s1[6:0], sout_w[1]};
                if (k == W - 1) chk("tbl_frame_last", int'(fl_w[0]), 1);
                step();
            end
            chk($sformatf("tbl_msb_seq_%0h", vecs[v].data), int'(s0), int'(vecs[v].msb_seq));
            chk($sformatf("tbl_lsb_seq_%0h", vecs[v].data), int'(s1), int'(vecs[v].lsb_seq));
            chk("tbl_idle_after", int'(sv_w[0]), 0);
            chk("tbl_word_count", int'(wc_w[0]), v + 1);
        end

        // ---- gapless stream D8 then 1B at edge 3 ----
        load_valid = 1'b1;
        load_data  = 8'hD8;
        step();
        s16 = '0;
        nv  = 0;
        for (int c = 1; c <= 16; c++) begin
            s16 = {s16[14:0], sout_w[0]};
            if (sv_w[0]) nv++;
            load_valid = (c == 3);
            load_data  = 8'h1B;
            step();
        end
        chk("gapless_valid_cycles", nv, 16);
        chk("gapless_bits", int'(s16), 32'hD81B);
        chk("gapless_idle_after", int'(sv_w[0]), 0);

        // ---- backpressure with load_valid held high ----
        words[0] = 8'h3C;
        words[1] = 8'hC5;
        words[2] = 8'h96;
        idx = 0;
        load_valid = 1'b1;
        load_data  = words[0];
        s24 = '0;
        nv  = 0;
        for (int e = 0; e <= 26; e++) begin
            step();
            if (last_xfer) begin
                xe.push_back(e);
                idx++;
                if (idx == 3) load_valid = 1'b0;
                else          load_data  = words[idx];
            end
            if (e == 1) chk("bp_ready_low_after_hold", int'(ready_w[0]), 0);
            if (e < 24) begin
                s24 = {s24[22:0], sout_w[0]};
                if (sv_w[0]) nv++;
            end
        end
        chk("bp_num_xfers", xe.size(), 3);
        if (xe.size() == 3) begin
            chk("bp_xfer_A_edge", xe[0], 0);
            chk("bp_xfer_B_edge", xe[1], 1);
            chk("bp_xfer_C_edge", xe[2], 9);
        end
        chk("bp_valid_cycles", nv, 24);
        chk("bp_bits", int'(s24), 32'h3CC596);
        chk("bp_idle_after", int'(sv_w[0]), 0);

        // ---- reset mid-word, then 8'h80 ----
        load_valid = 1'b1;
        load_data  = 8'hFF;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("midrst_bit4_position", int'(bc_w[0]), 4);
        do_reset();
        load_valid = 1'b1;
        load_data  = 8'h80;
        step();
        load_valid = 1'b0;
        s0 = '0;
        for (int k = 0; k < W; k++) begin
            s0 = {s0[6:0], sout_w[0]};
            step();
        end
        chk("midrst_after_bits", int'(s0), 32'h80);
        chk("midrst_word_count", int'(wc_w[0]), 1);

        // ---- randomized stream of 256 words, counter wrap ----
        do_reset();
        sent   = 0;
        fin    = 1'b0;
        hit255 = 1'b0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            load_valid = (sent < 256) && ($urandom_range(0, 3) != 0);
            load_data  = 8'($urandom);
            prev = done;
            step();
            if (last_xfer) sent++;
            if (done != prev && done == 255) begin
                hit255 = 1'b1;
                chk("wrap_count_255", int'(wc_w[0]), 255);
            end
            if (done != prev && done == 256) begin
                fin = 1'b1;
                chk("wrap_count_0", int'(wc_w[0]), 0);
            end
        end
        load_valid = 1'b0;
        chk("wrap_reached_255", int'(hit255), 1);
        chk("wrap_finished_in_budget", int'(fin), 1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
